regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file, the successor to the single-cycle CPU register bank.
- One synchronous write port; NUM_RD combinational read ports.
- x0 hardwired to zero.
- Contents are cleared by a hardware init sequencer after reset or on request, not by a loaded memory image.
- Sits in the decode stage; feeds ALU operands and store data.

Parameters:
DATA_W, 32, register width in bits
NUM_REG, 32, number of architectural registers (2..2**ADDR_W)
ADDR_W, 5, register address width
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  request re-run of clear sequence (sampled only while ready=1)
ready  out  1  1 = file initialised, accepting writes, reads valid
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]

Behaviour:
- Clock/reset: single clock clk; reset rst_n asynchronous, active-low.
- rst_n=0 sets FSM=INIT and cnt=1 immediately; ready=0 at once. Storage array is not reset.
- INIT state, each posedge: mem[cnt]<=0.
  - If cnt==NUM_REG-1: FSM<=READY, cnt<=1.
  - Else cnt<=cnt+1.
  - ready rises exactly NUM_REG-1 edges after rst_n deassertion (31 for defaults).
- READY state: clr_req=1 at a posedge moves FSM<=INIT, cnt<=1.
- clr_req while in INIT is ignored; the sequence is not restarted.
- ready is decoded from the state register only (no combinational path from inputs).
- Write: performed at posedge when we=1, ready=1, waddr!=0 and waddr<NUM_REG. Otherwise dropped.
  - A write coincident with clr_req is performed; the subsequent clear overwrites it.
  - Writes during INIT are dropped silently.
- Read (combinational, zero latency), per port:
  - rdata=0 if ready=0, raddr==0 or raddr>=NUM_REG.
  - Else rdata=mem[raddr], subject to bypass (see Optional Feature).
- Reset asserted mid-clear: sequence restarts from cnt=1.
- Multiple ports reading the same address return identical data.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-first forwarding. A read port sees rdata=wdata in the same cycle when we=1, ready=1, waddr!=0, waddr<NUM_REG and raddr==waddr.
- Undefined: the read returns the old contents until after the write edge.

Decomposition:
- Package regfile_pkg holds:
  - state enum {INIT, READY}
  - default DATA_W/ADDR_W/NUM_REG constants
  - a ZERO_REG=0 constant
- Sub-module regfile_init_ctrl holds the FSM and clear counter.
  - Outputs: ready, clr_we, clr_addr.
  - The top muxes clr_we/clr_addr/0 onto the storage write path.

Test Plan:
- Reset release: rst_n 0->1, count edges -> ready=0 for 31 edges, 1 after the 31st; all rdata=0 throughout; every register then reads 0.
- Write/read: write x5=0xDEADBEEF, next cycle raddr0=5, raddr1=5 -> both ports 0xDEADBEEF. Write x0=0x1234 -> x0 still reads 0.
- Bypass: we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7 in same cycle. With REGFILE_BYPASS_EN -> rdata0=0xA5A5A5A5. Without -> old value (0).
- Clear request: fill x1..x31 with nonzero, pulse clr_req one cycle -> ready low for 31 edges, writes issued meanwhile dropped, all registers read 0 after.
- Reset mid-clear: assert rst_n=0 at cnt=10 for 2 cycles -> ready stays 0; full 31-edge sequence repeats after release.
- Out of range: NUM_REG=16, ADDR_W=5; write addr 20 -> dropped; read addr 20 -> 0; ready after 15 edges.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NUM_REG = 32;
  localparam int ZERO_REG    = 0;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Clear sequencer: walks x1..x(NUM_REG-1) writing zero after reset or on clr_req_i,
// then holds READY; clr_req_i is ignored while a clear is in progress.
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int NUM_REG = DEF_NUM_REG,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REG - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = FIRST;
        end else begin
          cnt_d = cnt_q + FIRST;
        end
      end
      READY: begin
        if (clr_req_i) begin
          state_d = INIT;
          cnt_d   = FIRST;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = FIRST;
      end
    endcase
  end

  // Outputs come straight from the state register, never from inputs.
  assign ready_o    = (state_q == READY);
  assign clr_we_o   = (state_q == INIT);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Register file: one sync write port, NUM_RD combinational read ports, x0 reads zero.
// Optional write-first forwarding to read ports when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_REG = DEF_NUM_REG,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int                IDX_W  = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [ADDR_W:0]   LIMIT  = (ADDR_W + 1)'(NUM_REG);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != ZERO_A) && ({1'b0, a} < LIMIT);
  endfunction

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] mem_q [NUM_REG];

  regfile_init_ctrl #(
    .NUM_REG (NUM_REG),
    .ADDR_W  (ADDR_W)
  ) u_init_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (clr_req),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Clear owns the write path during INIT; user writes are only legal when ready.
  assign wr_ok   = we && ready && addr_ok(waddr);
  assign wr_en   = clr_we || wr_ok;
  assign wr_addr = clr_we ? clr_addr : waddr;
  assign wr_dat  = clr_we ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr[IDX_W-1:0]] <= wr_dat;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (ready && addr_ok(ra)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (ra == waddr)) begin
          rd = wdata;
        end else begin
          rd = mem_q[ra[IDX_W-1:0]];
        end
`else
        rd = mem_q[ra[IDX_W-1:0]];
`endif
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32-entry instance plus a 16-entry instance.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        clr_req, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        ready;

  logic        clr_req16, we16;
  logic [4:0]  waddr16;
  logic [31:0] wdata16;
  logic [9:0]  raddr16;
  logic [63:0] rdata16;
  logic        ready16;

  int n_cmp = 0;
  int n_err = 0;
  int n_edges, n16_edges, zbad;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  regfile_mp #(.NUM_REG(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req16), .ready(ready16),
    .we(we16), .waddr(waddr16), .wdata(wdata16), .raddr(raddr16), .rdata(rdata16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts edges until each instance is ready (bounded); optionally hammers
  // writes and clr_req while the default instance is still clearing.
  task automatic wait_ready(output int n, output int n16, output int bad, input bit disturb);
    int e;
    n = 0; n16 = 0; bad = 0; e = 0;
    if (disturb) begin
      we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF; clr_req = 1'b1;
    end
    while ((n == 0 || n16 == 0) && e < 64) begin
      @(posedge clk); #1;
      e++;
      if (ready && n == 0) begin
        n = e;
        we = 1'b0; clr_req = 1'b0;
      end
      if (ready16 && n16 == 0) n16 = e;
      if (!ready && rdata !== 64'd0) bad++;
    end
    we = 1'b0; clr_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      raddr = {5'(31 - r), 5'(r)};
      #1;
      if (rdata !== 64'd0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    clr_req16 = 1'b0; we16 = 1'b0; waddr16 = '0; wdata16 = '0; raddr16 = '0;

    repeat (3) @(posedge clk);
    #1;
    raddr = {5'd31, 5'd5};
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ready16", 32'(ready16), 32'd0);
    check("rst_rdata", rdata[31:0], 32'd0);
    #1 rst_n = 1'b1;

    wait_ready(n_edges, n16_edges, zbad, 1'b0);
    check("init_edges", 32'(n_edges), 32'd31);
    check("init16_edges", 32'(n16_edges), 32'd15);
    check("init_rdata_low", 32'(zbad), 32'd0);
    chk_all_zero("init_zero");

    // Plain write then two-port read of the same register.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    we = 1'b0; raddr = {5'd5, 5'd5};
    #1;
    check("wr_rd_p0", rdata[31:0], 32'hDEAD_BEEF);
    check("wr_rd_p1", rdata[63:32], 32'hDEAD_BEEF);

    we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    we = 1'b0; raddr = {5'd5, 5'd0};
    #1;
    check("x0_zero", rdata[31:0], 32'd0);
    check("x5_kept", rdata[63:32], 32'hDEAD_BEEF);

    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr = {5'd5, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same", rdata[31:0], 32'hA5A5_A5A5);
`else
    check("byp_same", rdata[31:0], 32'd0);
`endif
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("byp_after", rdata[31:0], 32'hA5A5_A5A5);

    for (int r = 1; r < 32; r++) begin
      we = 1'b1; waddr = 5'(r); wdata = 32'h1000_0000 | 32'(r);
      @(posedge clk); #1;
    end
    we = 1'b0; raddr = {5'd31, 5'd1};
    #1;
    check("fill_x1", rdata[31:0], 32'h1000_0001);
    check("fill_x31", rdata[63:32], 32'h1000_001F);

    // Clear request with a coincident write; the clear must win.
    clr_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    clr_req = 1'b0; we = 1'b0;
    check("clr_ready", 32'(ready), 32'd0);
    wait_ready(n_edges, n16_edges, zbad, 1'b1);
    check("clr_edges", 32'(n_edges - 1), 32'd30);
    check("clr_rdata_low", 32'(zbad), 32'd0);
    chk_all_zero("clr_zero");

    // Reset arrives partway through a clear.
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_ready", 32'(ready), 32'd0);
    check("mrst_ready16", 32'(ready16), 32'd0);
    rst_n = 1'b1;
    wait_ready(n_edges, n16_edges, zbad, 1'b0);
    check("mrst_edges", 32'(n_edges), 32'd31);
    check("mrst16_edges", 32'(n16_edges), 32'd15);
    chk_all_zero("mrst_zero");

    // Out-of-range addresses on the 16-entry instance.
    we16 = 1'b1; waddr16 = 5'd20; wdata16 = 32'h0000_0055;
    @(posedge clk); #1;
    we16 = 1'b0; raddr16 = {5'd4, 5'd20};
    #1;
    check("oor_read20", rdata16[31:0], 32'd0);
    check("oor_alias4", rdata16[63:32], 32'd0);
    we16 = 1'b1; waddr16 = 5'd15; wdata16 = 32'h0000_0077;
    @(posedge clk); #1;
    we16 = 1'b0; raddr16 = {5'd16, 5'd15};
    #1;
    check("r16_x15", rdata16[31:0], 32'h0000_0077);
    check("r16_read16", rdata16[63:32], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
